// File: rtl/tmr32_pwm_sequencer.sv
// Table-driven period/compare sequencer for a 32-bit timer/PWM core.
// Steps through programmed entries on each timer time-out, with per-entry repeat counts.
module tmr32_pwm_sequencer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    localparam int unsigned PW   = 32,
    localparam int unsigned RW   = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start,
    input  logic          stop,
    input  logic          loop,
    input  logic [AW:0]   num_ent,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [PW-1:0] wr_period,
    input  logic [PW-1:0] wr_cmp,
    input  logic [RW-1:0] wr_rpt,
    input  logic          to_flag,
    output logic [PW-1:0] period,
    output logic [PW-1:0] pwm_cmp,
    output logic          tmr_en,
    output logic          pwm_en,
    output logic          busy,
    output logic [AW-1:0] cur_idx,
    output logic          seq_done,
    output logic          err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [1:0]    state, state_n;
    logic [AW-1:0] idx, idx_n;
    logic [RW-1:0] rpt_cnt, rpt_n;
    logic [AW:0]   num_lat, num_n;
    logic          loop_lat, loop_n;
    logic          load_en;
    logic          err_n;
    logic [AW:0]   last_idx;

    logic [PW-1:0] tbl_period [DEPTH];
    logic [PW-1:0] tbl_cmp    [DEPTH];
    logic [RW-1:0] tbl_rpt    [DEPTH];

    assign last_idx = num_lat - (AW+1)'(1);
    assign busy     = (state != IDLE);

    // Step table; writable at any time, only sampled when an entry is loaded
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                tbl_period[i] <= '0;
                tbl_cmp[i]    <= '0;
                tbl_rpt[i]    <= '0;
            end
        end else if (wr_en) begin
            tbl_period[wr_idx] <= wr_period;
            tbl_cmp[wr_idx]    <= wr_cmp;
            tbl_rpt[wr_idx]    <= wr_rpt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    end

    // Next state; stop outranks to_flag, which outranks start
    always_comb begin
        state_n = state;
        idx_n   = idx;
        rpt_n   = rpt_cnt;
        num_n   = num_lat;
        loop_n  = loop_lat;
        load_en = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    if (num_ent != '0 && num_ent <= DEPTH_W) begin
                        num_n   = num_ent;
                        loop_n  = loop;
                        idx_n   = '0;
                        state_n = LOAD;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (stop) begin
                    state_n = IDLE;
                end else begin
                    load_en = 1'b1;
                    rpt_n   = tbl_rpt[idx];
                    state_n = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (to_flag) begin
                    if (rpt_cnt != '0) begin
                        rpt_n = rpt_cnt - RW'(1);
                    end else if ({1'b0, idx} < last_idx) begin
                        idx_n   = idx + AW'(1);
                        state_n = LOAD;
                    end else if (loop_lat) begin
                        idx_n   = '0;
                        state_n = LOAD;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs registered from the next state so they line up with it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx      <= '0;
            rpt_cnt  <= '0;
            num_lat  <= '0;
            loop_lat <= 1'b0;
            period   <= '0;
            pwm_cmp  <= '0;
            cur_idx  <= '0;
            tmr_en   <= 1'b0;
            pwm_en   <= 1'b0;
            seq_done <= 1'b0;
            err      <= 1'b0;
        end else begin
            idx      <= idx_n;
            rpt_cnt  <= rpt_n;
            num_lat  <= num_n;
            loop_lat <= loop_n;
            tmr_en   <= (state_n == RUN);
            pwm_en   <= (state_n == RUN);
            seq_done <= (state_n == DONE);
            err      <= err_n;
            if (load_en) begin
                period  <= tbl_period[idx];
                pwm_cmp <= tbl_cmp[idx];
                cur_idx <= idx;
            end
        end
    end

endmodule

// File: tb/tb_tmr32_pwm_sequencer.sv
// Bench for tmr32_pwm_sequencer: directed scenarios plus randomized tables,
// checked against an expanded list of (period, cmp, index) steps built from a shadow table.
module tb_tmr32_pwm_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start, stop, loop, wr_en, to_flag;
    logic [3:0]  num_ent;
    logic [2:0]  wr_idx;
    logic [31:0] wr_period, wr_cmp;
    logic [15:0] wr_rpt;
    logic [31:0] period, pwm_cmp;
    logic        tmr_en, pwm_en, busy, seq_done, err;
    logic [2:0]  cur_idx;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] sh_p [8];
    logic [31:0] sh_c [8];
    logic [15:0] sh_r [8];

    logic [31:0] exp_p [$];
    logic [31:0] exp_c [$];
    int          exp_i [$];
    bit          exp_first [$];
    logic [31:0] obs_p [$];
    logic [2:0]  obs_i [$];

    tmr32_pwm_sequencer dut (
        .clk_i(clk_i), .rst_i(rst_i), .start(start), .stop(stop), .loop(loop),
        .num_ent(num_ent), .wr_en(wr_en), .wr_idx(wr_idx), .wr_period(wr_period),
        .wr_cmp(wr_cmp), .wr_rpt(wr_rpt), .to_flag(to_flag), .period(period),
        .pwm_cmp(pwm_cmp), .tmr_en(tmr_en), .pwm_en(pwm_en), .busy(busy),
        .cur_idx(cur_idx), .seq_done(seq_done), .err(err)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic write_ent(input int i, input logic [31:0] p, input logic [31:0] c,
                             input logic [15:0] r);
        wr_en = 1'b1; wr_idx = 3'(i); wr_period = p; wr_cmp = c; wr_rpt = r;
        tick();
        wr_en = 1'b0;
        sh_p[i] = p; sh_c[i] = c; sh_r[i] = r;
    endtask

    task automatic do_start(input int n, input bit lp);
        start = 1'b1; num_ent = 4'(n); loop = lp;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_busy", busy, 0);
        check("stop_tmr_en", tmr_en, 0);
        check("stop_pwm_en", pwm_en, 0);
        check("stop_seq_done", seq_done, 0);
    endtask

    task automatic pulse_to();
        to_flag = 1'b1;
        tick();
        to_flag = 1'b0;
    endtask

    task automatic check_run(input int j);
        check("run_tmr_en", tmr_en, 1);
        check("run_pwm_en", pwm_en, 1);
        check("run_busy", busy, 1);
        check("run_seq_done", seq_done, 0);
        check("run_period", period, exp_p[j]);
        check("run_cmp", pwm_cmp, exp_c[j]);
        check("run_cur_idx", 32'(cur_idx), 32'(exp_i[j]));
        obs_p.push_back(period);
        obs_i.push_back(cur_idx);
    endtask

    // Expand the shadow table into one element per timer period, then follow it
    task automatic run_model(input int n, input bit lp, input int n_to);
        int len;
        int pos;
        exp_p.delete(); exp_c.delete(); exp_i.delete(); exp_first.delete();
        for (int i = 0; i < n; i++) begin
            for (int r = 0; r <= int'(sh_r[i]); r++) begin
                exp_p.push_back(sh_p[i]);
                exp_c.push_back(sh_c[i]);
                exp_i.push_back(i);
                exp_first.push_back(r == 0);
            end
        end
        len = exp_p.size();
        do_start(n, lp);
        check("load_busy", busy, 1);
        check("load_tmr_en", tmr_en, 0);
        tick();
        check_run(0);
        for (int k = 0; k < n_to; k++) begin
            repeat ($urandom_range(0, 3)) tick();
            pulse_to();
            pos = k + 1;
            if (!lp && pos == len) begin
                check("done_pulse", seq_done, 1);
                check("done_tmr_en", tmr_en, 0);
                check("done_pwm_en", pwm_en, 0);
                check("done_busy", busy, 1);
                check("done_period_hold", period, exp_p[len-1]);
                tick();
                check("after_done_busy", busy, 0);
                check("after_done_seq_done", seq_done, 0);
                break;
            end
            if (exp_first[pos % len]) begin
                check("reload_tmr_en", tmr_en, 0);
                check("reload_seq_done", seq_done, 0);
                tick();
            end
            check_run(pos % len);
        end
    endtask

    initial begin
        rst_i = 1'b1; start = 0; stop = 0; loop = 0; wr_en = 0; to_flag = 0;
        num_ent = '0; wr_idx = '0; wr_period = '0; wr_cmp = '0; wr_rpt = '0;
        for (int i = 0; i < 8; i++) begin sh_p[i] = 0; sh_c[i] = 0; sh_r[i] = 0; end
        tick();
        check("rst_period", period, 0);
        check("rst_cmp", pwm_cmp, 0);
        check("rst_tmr_en", tmr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        rst_i = 1'b0;
        tick();

        write_ent(0, 10, 5, 0);
        write_ent(1, 20, 8, 1);
        write_ent(2, 4, 2, 0);

        // Three-entry one-shot sequence
        obs_p.delete(); obs_i.delete();
        run_model(3, 0, 4);
        check("seq_cnt", 32'(obs_p.size()), 4);
        if (obs_p.size() == 4) begin
            check("seq_p0", obs_p[0], 10); check("seq_p1", obs_p[1], 20);
            check("seq_p2", obs_p[2], 20); check("seq_p3", obs_p[3], 4);
            check("seq_i1", 32'(obs_i[1]), 1); check("seq_i3", 32'(obs_i[3]), 2);
        end

        // Looping sequence, 8 time-outs, never completes
        run_model(3, 1, 8);
        check("loop_busy", busy, 1);
        do_stop();

        // Stop while entry 1 is active, then restart from entry 0
        run_model(3, 0, 1);
        check("pre_stop_idx", 32'(cur_idx), 1);
        do_stop();
        run_model(3, 0, 0);
        do_stop();

        // to_flag and stop together: stop wins
        run_model(3, 0, 0);
        to_flag = 1'b1; stop = 1'b1;
        tick();
        to_flag = 1'b0; stop = 1'b0;
        check("tostop_busy", busy, 0);
        check("tostop_tmr_en", tmr_en, 0);
        check("tostop_seq_done", seq_done, 0);

        // to_flag during LOAD is ignored
        do_start(3, 0);
        tick();
        pulse_to();
        check("ldign_load", tmr_en, 0);
        to_flag = 1'b1;
        tick();
        to_flag = 1'b0;
        check("ldign_run_idx", 32'(cur_idx), 1);
        check("ldign_run_en", tmr_en, 1);
        pulse_to();
        check("ldign_repeat_en", tmr_en, 1);
        check("ldign_repeat_idx", 32'(cur_idx), 1);
        pulse_to();
        check("ldign_next_load", tmr_en, 0);
        tick();
        check("ldign_e2_idx", 32'(cur_idx), 2);
        check("ldign_e2_period", period, 4);
        do_stop();

        // Rewrite active entry 0; takes effect only at the wrap
        run_model(3, 1, 0);
        write_ent(0, 99, 5, 0);
        check("rewrite_hold", period, 10);
        pulse_to(); tick();
        pulse_to(); pulse_to(); tick();
        pulse_to(); tick();
        check("rewrite_wrap_period", period, 99);
        check("rewrite_wrap_idx", 32'(cur_idx), 0);
        do_stop();

        // Illegal num_ent
        do_start(0, 0);
        check("err0_pulse", err, 1);
        check("err0_busy", busy, 0);
        check("err0_period", period, 99);
        tick();
        check("err0_clear", err, 0);
        do_start(9, 0);
        check("err9_pulse", err, 1);
        check("err9_busy", busy, 0);
        check("err9_cmp", pwm_cmp, 5);
        tick();
        check("err9_clear", err, 0);

        // Asynchronous reset mid-RUN, away from any clock edge
        run_model(3, 0, 1);
        #3 rst_i = 1'b1;
        #1;
        check("arst_period", period, 0);
        check("arst_cmp", pwm_cmp, 0);
        check("arst_tmr_en", tmr_en, 0);
        check("arst_pwm_en", pwm_en, 0);
        check("arst_busy", busy, 0);
        check("arst_cur_idx", 32'(cur_idx), 0);
        check("arst_seq_done", seq_done, 0);
        #2 rst_i = 1'b0;
        for (int i = 0; i < 8; i++) begin sh_p[i] = 0; sh_c[i] = 0; sh_r[i] = 0; end
        tick();
        run_model(1, 0, 0);
        do_stop();

        // Randomized tables and sequence shapes
        for (int t = 0; t < 6; t++) begin
            int n;
            int len;
            bit lp;
            for (int i = 0; i < 8; i++)
                write_ent(i, $urandom, $urandom, 16'($urandom_range(0, 2)));
            n  = $urandom_range(1, 8);
            lp = 1'($urandom_range(0, 1));
            len = 0;
            for (int i = 0; i < n; i++) len += int'(sh_r[i]) + 1;
            run_model(n, lp, lp ? len + $urandom_range(1, len) : len);
            if (lp) do_stop();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
